// File: rtl/gcd_pkg.sv
// Shared types and default constants for the GCD initiator front end.
package gcd_pkg;

    localparam int unsigned GCD_W         = 5;
    localparam int unsigned GCD_TO_CYCLES = 64;
    localparam int unsigned GCD_CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } gcd_state_e;

endpackage

// File: rtl/gcd_initiator_if.sv
// Upstream pair, engine start/done and downstream result channels of the GCD initiator.
interface gcd_initiator_if
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         eng_start;
    logic [W-1:0] eng_a;
    logic [W-1:0] eng_b;
    logic         eng_done;
    logic [W-1:0] eng_result;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic [W-1:0] out_gcd;
    logic         out_err;

    // initiator side
    modport master (
        input  in_valid, in_a, in_b, eng_done, eng_result, out_ready,
        output in_ready, eng_start, eng_a, eng_b,
        output out_valid, out_a, out_b, out_gcd, out_err
    );

    // upstream / engine / downstream side
    modport slave (
        output in_valid, in_a, in_b, eng_done, eng_result, out_ready,
        input  in_ready, eng_start, eng_a, eng_b,
        input  out_valid, out_a, out_b, out_gcd, out_err
    );

endinterface

// File: rtl/gcd_initiator.sv
// Sequences one operand pair at a time through a GCD engine; zero operands resolve locally.
// Optional engine watchdog enabled by defining GCD_INIT_TIMEOUT_EN.
module gcd_initiator
    import gcd_pkg::*;
#(
    parameter int unsigned W         = GCD_W,
`ifdef GCD_INIT_TIMEOUT_EN
    parameter int unsigned TO_CYCLES = GCD_TO_CYCLES,
`endif
    parameter int unsigned CNT_W     = GCD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    gcd_initiator_if.master  bus,
    output logic [CNT_W-1:0] txn_count
);

    gcd_state_e state;
    gcd_state_e state_nxt;

    logic             zero_op;
    logic             done_hit;
    logic             timeout_hit;
    logic             out_fire;

    logic             in_ready_nxt;
    logic             eng_start_nxt;
    logic             out_valid_nxt;
    logic [W-1:0]     eng_a_nxt;
    logic [W-1:0]     eng_b_nxt;
    logic [W-1:0]     out_a_nxt;
    logic [W-1:0]     out_b_nxt;
    logic [W-1:0]     out_gcd_nxt;
    logic [CNT_W-1:0] txn_count_nxt;

    assign zero_op  = (bus.in_a == '0) || (bus.in_b == '0);
    assign done_hit = (state == WAIT) && bus.eng_done;
    assign out_fire = (state == HOLD) && bus.out_ready;

`ifdef GCD_INIT_TIMEOUT_EN
    localparam int unsigned TO_CNT_W = $clog2(TO_CYCLES + 1);

    logic [TO_CNT_W-1:0] wait_cnt;
    logic                out_err_nxt;

    // Counts completed WAIT cycles; a coincident eng_done beats the limit.
    always_ff @(posedge clk) begin
        if (rst || (state == ISSUE)) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TO_CNT_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT) && !bus.eng_done &&
                         (wait_cnt == TO_CNT_W'(TO_CYCLES - 1));

    always_comb begin
        out_err_nxt = bus.out_err;
        if ((state == IDLE) && bus.in_valid) begin
            out_err_nxt = 1'b0;
        end else if (timeout_hit) begin
            out_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_err <= 1'b0;
        end else begin
            bus.out_err <= out_err_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus.out_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = zero_op ? HOLD : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_hit || timeout_hit) state_nxt = HOLD;
            HOLD:    if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE);
        eng_start_nxt = (state_nxt == ISSUE);
        out_valid_nxt = (state_nxt == HOLD);
        eng_a_nxt     = bus.eng_a;
        eng_b_nxt     = bus.eng_b;
        out_a_nxt     = bus.out_a;
        out_b_nxt     = bus.out_b;
        out_gcd_nxt   = bus.out_gcd;
        txn_count_nxt = txn_count + CNT_W'(out_fire);

        if ((state == IDLE) && bus.in_valid) begin
            out_a_nxt = bus.in_a;
            out_b_nxt = bus.in_b;
            if (zero_op) begin
                // gcd(x,0) = x and gcd(0,0) = 0, so OR covers every zero case
                out_gcd_nxt = bus.in_a | bus.in_b;
            end else begin
                eng_a_nxt = bus.in_a;
                eng_b_nxt = bus.in_b;
            end
        end else if (done_hit) begin
            out_gcd_nxt = bus.eng_result;
        end else if (timeout_hit) begin
            out_gcd_nxt = '0;
        end
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready  <= 1'b1;
            bus.eng_start <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.eng_a     <= '0;
            bus.eng_b     <= '0;
            bus.out_a     <= '0;
            bus.out_b     <= '0;
            bus.out_gcd   <= '0;
            txn_count     <= '0;
        end else begin
            bus.in_ready  <= in_ready_nxt;
            bus.eng_start <= eng_start_nxt;
            bus.out_valid <= out_valid_nxt;
            bus.eng_a     <= eng_a_nxt;
            bus.eng_b     <= eng_b_nxt;
            bus.out_a     <= out_a_nxt;
            bus.out_b     <= out_b_nxt;
            bus.out_gcd   <= out_gcd_nxt;
            txn_count     <= txn_count_nxt;
        end
    end

endmodule

// File: tb/tb_gcd_initiator.sv
// Randomized self-checking bench for gcd_initiator with a transaction-level reference model.
module tb_gcd_initiator;
    import gcd_pkg::*;

    localparam int unsigned W  = GCD_W;
    localparam int          TO = 64;

    logic         clk;
    logic         rst;
    logic [7:0]   txn_count;

    gcd_initiator_if #(.W(W)) bus ();

    gcd_initiator dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = int'(a);
        int y = int'(b);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // reference model: what must be visible on the ports, phase by phase
    bit           m_start, m_wait, m_present, m_err;
    int           m_elapsed;
    logic [W-1:0] m_ea, m_eb, m_oa, m_ob, m_gcd;
    logic [7:0]   m_cnt;
    logic [W-1:0] sb_a[$];
    logic [W-1:0] sb_b[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_start = 0; m_wait = 0; m_present = 0; m_err = 0; m_cnt = '0;
            sb_a.delete(); sb_b.delete();
        end else if (m_present) begin
            if (bus.out_ready) begin
                m_present = 0;
                m_cnt     = m_cnt + 8'd1;
            end
        end else if (m_start) begin
            m_start   = 0;
            m_wait    = 1;
            m_elapsed = 0;
        end else if (m_wait) begin
            m_elapsed++;
            if (bus.eng_done) begin
                m_wait = 0; m_present = 1; m_gcd = bus.eng_result; m_err = 0;
            end
`ifdef GCD_INIT_TIMEOUT_EN
            else if (m_elapsed == TO) begin
                m_wait = 0; m_present = 1; m_gcd = '0; m_err = 1;
            end
`endif
        end else if (bus.in_valid) begin
            m_oa = bus.in_a;
            m_ob = bus.in_b;
            m_err = 0;
            sb_a.push_back(bus.in_a);
            sb_b.push_back(bus.in_b);
            if (bus.in_a == '0 || bus.in_b == '0) begin
                m_present = 1;
                m_gcd     = gcd_ref(bus.in_a, bus.in_b);
            end else begin
                m_start = 1;
                m_ea    = bus.in_a;
                m_eb    = bus.in_b;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready",  32'(bus.in_ready),  32'(!(m_start || m_wait || m_present)));
            check("eng_start", 32'(bus.eng_start), 32'(m_start));
            check("out_valid", 32'(bus.out_valid), 32'(m_present));
            check("txn_count", 32'(txn_count),     32'(m_cnt));
            if (m_start || m_wait) begin
                check("eng_a", 32'(bus.eng_a), 32'(m_ea));
                check("eng_b", 32'(bus.eng_b), 32'(m_eb));
            end
            if (m_present) begin
                check("out_a",   32'(bus.out_a),   32'(m_oa));
                check("out_b",   32'(bus.out_b),   32'(m_ob));
                check("out_gcd", 32'(bus.out_gcd), 32'(m_gcd));
                check("out_err", 32'(bus.out_err), 32'(m_err));
                if (bus.out_ready) begin
                    check("sb_nonempty", 32'(sb_a.size() > 0), 32'd1);
                    if (sb_a.size() > 0) begin
                        check("sb_a", 32'(bus.out_a), 32'(sb_a[0]));
                        check("sb_b", 32'(bus.out_b), 32'(sb_b[0]));
                        check("sb_gcd", 32'(bus.out_gcd),
                              m_err ? 32'd0 : 32'(gcd_ref(sb_a[0], sb_b[0])));
                        void'(sb_a.pop_front());
                        void'(sb_b.pop_front());
                    end
                end
            end
        end
    end

    // engine start observer
    int           starts = 0;
    logic [W-1:0] st_a, st_b;
    always @(negedge clk) begin
        if (!rst && bus.eng_start === 1'b1) begin
            starts++;
            st_a = bus.eng_a;
            st_b = bus.eng_b;
        end
    end

    // engine model: eng_done eng_lat cycles after eng_start, optional noise
    int eng_lat    = 5;
    bit lat_rand   = 0;
    bit silent     = 0;
    bit spur_en    = 0;
    bit spur_issue = 0;

    initial begin
        int           cnt;
        logic [W-1:0] pa, pb;
        cnt = 0;
        pa  = '0;
        pb  = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_done   = 1'b0;
            bus.eng_result = W'($urandom);
            if (bus.eng_start) begin
                cnt = lat_rand ? int'($urandom_range(1, 9)) : eng_lat;
                pa  = bus.eng_a;
                pb  = bus.eng_b;
                if (spur_issue || (spur_en && ($urandom % 3) == 0)) bus.eng_done = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !silent) begin
                    bus.eng_done   = 1'b1;
                    bus.eng_result = gcd_ref(pa, pb);
                end
            end else if (spur_en && ($urandom % 3) == 0) begin
                bus.eng_done = 1'b1;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        check("send_accepted", 32'(ok), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_result(input logic [W-1:0] ea, input logic [W-1:0] eb,
                               input logic [W-1:0] eg, input bit eerr, output int vc);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check("result_seen", 32'(seen), 32'd1);
        vc = cyc;
        check("res_a",   32'(bus.out_a),   32'(ea));
        check("res_b",   32'(bus.out_b),   32'(eb));
        check("res_gcd", 32'(bus.out_gcd), 32'(eg));
        check("res_err", 32'(bus.out_err), 32'(eerr));
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
        check({tag, "_txn_count"}, 32'(txn_count),     32'd0);
        check({tag, "_eng_a"},     32'(bus.eng_a),     32'd0);
        check({tag, "_eng_b"},     32'(bus.eng_b),     32'd0);
        check({tag, "_out_a"},     32'(bus.out_a),     32'd0);
        check({tag, "_out_b"},     32'(bus.out_b),     32'd0);
        check({tag, "_out_gcd"},   32'(bus.out_gcd),   32'd0);
    endtask

    function automatic logic [W-1:0] rnd_op();
        return (($urandom % 4) == 0) ? W'(0) : W'($urandom_range(1, 31));
    endfunction

    initial begin
        int a, v, s0;
        bit fire;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_reset_values("reset");
        tick();
        rst = 1'b0;
        tick();

        // engine path (27,15) -> 3, done 5 cycles after start
        eng_lat = 5;
        s0 = starts;
        send(5'd27, 5'd15, a);
        wait_result(5'd27, 5'd15, 5'd3, 1'b0, v);
        check("t1_latency", 32'(v - a), 32'd6);
        check("t1_starts",  32'(starts - s0), 32'd1);
        check("t1_eng_a",   32'(st_a), 32'd27);
        check("t1_eng_b",   32'(st_b), 32'd15);

        // zero operands resolved without the engine
        s0 = starts;
        send(5'd0, 5'd12, a);
        wait_result(5'd0, 5'd12, 5'd12, 1'b0, v);
        check("t2_latency", 32'(v - a), 32'd0);
        send(5'd0, 5'd0, a);
        wait_result(5'd0, 5'd0, 5'd0, 1'b0, v);
        check("t2_no_start", 32'(starts - s0), 32'd0);

        // downstream stall with a waiting upstream pair
        eng_lat = 3;
        bus.out_ready = 1'b0;
        send(5'd12, 5'd18, a);
        wait_result(5'd12, 5'd18, 5'd6, 1'b0, v);
        bus.in_valid = 1'b1;
        bus.in_a     = 5'd5;
        bus.in_b     = 5'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_in_ready", 32'(bus.in_ready),  32'd0);
            check("t3_valid",    32'(bus.out_valid), 32'd1);
            check("t3_out_a",    32'(bus.out_a),     32'd12);
            check("t3_out_gcd",  32'(bus.out_gcd),   32'd6);
        end
        tick();
        bus.out_ready = 1'b1;
        send(5'd5, 5'd5, a);
        wait_result(5'd5, 5'd5, 5'd5, 1'b0, v);

        // reset while waiting on the engine; its late done must be ignored
        eng_lat = 20;
        send(5'd27, 5'd15, a);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_reset_values("rst_wait");
        tick();
        rst = 1'b0;
        repeat (25) tick();
        check("t4_no_output", 32'(bus.out_valid), 32'd0);

        // consecutive pairs return in order
        eng_lat = 2;
        send(5'd12, 5'd8, a);
        wait_result(5'd12, 5'd8, 5'd4, 1'b0, v);
        send(5'd9, 5'd6, a);
        wait_result(5'd9, 5'd6, 5'd3, 1'b0, v);
        @(negedge clk);
        check("t5_txn_count", 32'(txn_count), 32'd2);
        tick();

        // done pulse during the start cycle carries a bogus value and is ignored
        spur_issue = 1;
        eng_lat    = 4;
        send(5'd20, 5'd15, a);
        spur_issue = 0;
        wait_result(5'd20, 5'd15, 5'd5, 1'b0, v);
        check("t6_latency", 32'(v - a), 32'd5);

`ifdef GCD_INIT_TIMEOUT_EN
        silent = 1;
        send(5'd27, 5'd15, a);
        wait_result(5'd27, 5'd15, 5'd0, 1'b1, v);
        check("t7_to_latency", 32'(v - a), 32'(TO + 1));
        silent  = 0;
        repeat (10) tick();
        eng_lat = TO;
        send(5'd9, 5'd6, a);
        wait_result(5'd9, 5'd6, 5'd3, 1'b0, v);
        check("t7_edge_latency", 32'(v - a), 32'(TO + 1));
`endif

        // randomized traffic with engine noise and downstream backpressure
        lat_rand = 1;
        spur_en  = 1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            tick();
            if (fire || !bus.in_valid) begin
                bus.in_valid = ($urandom % 3) != 0;
                bus.in_a     = rnd_op();
                bus.in_b     = rnd_op();
            end
            bus.out_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        fire = bus.in_valid && bus.in_ready;
        tick();
        if (fire) bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && bus.in_valid; i++) begin
            @(negedge clk);
            fire = bus.in_ready;
            tick();
            if (fire) bus.in_valid = 1'b0;
        end
        spur_en = 0;
        repeat (40) tick();
        check("sb_drained", 32'(sb_a.size()), 32'd0);
        check("rand_idle",  32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
